// File: rtl/ifm_load_pkg.sv
// Shared types for the IFM load sequencer: FSM state encoding and the
// element-index width helper used by the top and the address generator.
package ifm_load_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    DRAIN = 3'd2,
    HOLD  = 3'd3,
    FIN   = 3'd4
  } state_e;

  // Element index width for the default row of 16 buffers.
  localparam int unsigned DEF_NUM_PE = 16;
  localparam int unsigned ELEM_W     = $clog2(DEF_NUM_PE);

  // Element index width for an arbitrary row size (NUM_PE >= 2).
  function automatic int unsigned elem_width(input int unsigned num_pe);
    return (num_pe < 2) ? 1 : $clog2(num_pe);
  endfunction

endpackage

// File: rtl/ifm_load_addr_gen.sv
// SRAM address generator for the IFM load sequencer. Holds the base address
// of the current vector and the element index within it; the read address is
// their sum, wrapping modulo 2^ADDR_WIDTH. The stride is captured at job start.
module ifm_load_addr_gen #(
  parameter int ADDR_WIDTH = 16,
  parameter int NUM_PE     = 16,
  parameter int ELEM_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,      // job start: take base/stride, elem=0
  input  logic                  step_i,      // one element fetched
  input  logic                  next_vec_i,  // advance to the next vector
  input  logic [ADDR_WIDTH-1:0] base_i,
  input  logic [ADDR_WIDTH-1:0] stride_i,
  output logic [ELEM_W-1:0]     elem_o,
  output logic                  last_o,
  output logic [ADDR_WIDTH-1:0] addr_o
);

  logic [ADDR_WIDTH-1:0] vec_base_q, vec_base_d;
  logic [ADDR_WIDTH-1:0] stride_q, stride_d;
  logic [ELEM_W-1:0]     elem_q, elem_d;

  assign last_o = (elem_q == ELEM_W'(NUM_PE - 1));
  assign elem_o = elem_q;
  assign addr_o = vec_base_q + ADDR_WIDTH'(elem_q);

  // Next-state selection for vector base, stride and element index.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    vec_base_d = vec_base_q;
    stride_d   = stride_q;
    elem_d     = elem_q;
    if (load_i) begin
      vec_base_d = base_i;
      stride_d   = stride_i;
      elem_d     = '0;
    end else if (next_vec_i) begin
      vec_base_d = vec_base_q + stride_q;
      elem_d     = '0;
    end else if (step_i) begin
      elem_d     = last_o ? '0 : elem_q + ELEM_W'(1);
    end
  end

  // Address state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      vec_base_q <= '0;
      stride_q   <= '0;
      elem_q     <= '0;
    end else begin
      vec_base_q <= vec_base_d;
      stride_q   <= stride_d;
      elem_q     <= elem_d;
    end
  end

endmodule

// File: rtl/ifm_load_ctrl.sv
// IFM load sequencer: fetches one vector of NUM_PE words per job step from the
// IFM SRAM (one read per cycle), writes each word into its buffer register one
// cycle later via a one-hot strobe, then holds vec_valid until the PE array
// accepts it. Optional zero padding of partial vectors: IFM_LOAD_ZPAD_EN.
module ifm_load_ctrl
  import ifm_load_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_PE     = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int CNT_WIDTH  = 12
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [ADDR_WIDTH-1:0]        cfg_base_addr,
  input  logic [ADDR_WIDTH-1:0]        cfg_stride,
  input  logic [CNT_WIDTH-1:0]         cfg_num_vec,
  input  logic [$clog2(NUM_PE+1)-1:0]  cfg_valid_len,
  output logic                         mem_rd_en,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  input  logic [DATA_WIDTH-1:0]        mem_rd_data,
  output logic [NUM_PE-1:0]            set_ifm,
  output logic [DATA_WIDTH-1:0]        ifm_data,
  output logic                         vec_valid,
  input  logic                         vec_ready,
  output logic                         busy,
  output logic                         done
);

  localparam int ELEM_BITS = elem_width(NUM_PE);
  localparam int VL_W      = $clog2(NUM_PE + 1);

  state_e                 state_q;
  logic [CNT_WIDTH-1:0]   vec_cnt_q;
  logic [CNT_WIDTH-1:0]   num_vec_q;
  logic [NUM_PE-1:0]      set_ifm_q;   // write-back strobe, one cycle behind the read
  logic                   wb_zero_q;   // write-back slot carries padding, not SRAM data
  logic [ELEM_BITS-1:0]   elem;
  logic                   elem_last;
  logic                   elem_in_range;
  logic                   job_load;
  logic                   handshake;
  logic                   last_vec;

  assign job_load  = (state_q == IDLE) && start;
  assign handshake = (state_q == HOLD) && vec_ready;
  assign last_vec  = (vec_cnt_q == num_vec_q - CNT_WIDTH'(1));

  ifm_load_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_PE     (NUM_PE),
    .ELEM_W     (ELEM_BITS)
  ) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (job_load),
    .step_i     (state_q == FETCH),
    .next_vec_i (handshake && !last_vec),
    .base_i     (cfg_base_addr),
    .stride_i   (cfg_stride),
    .elem_o     (elem),
    .last_o     (elem_last),
    .addr_o     (mem_addr)
  );

`ifdef IFM_LOAD_ZPAD_EN
  logic [VL_W-1:0] valid_len_q;

  // Capture the per-vector element count at job start, clamped to the row size.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_len_q <= '0;
    end else if (job_load) begin
      valid_len_q <= (cfg_valid_len > VL_W'(NUM_PE)) ? VL_W'(NUM_PE) : cfg_valid_len;
    end
  end

  assign elem_in_range = (VL_W'(elem) < valid_len_q);
`else
  logic unused_cfg_valid_len;
  assign unused_cfg_valid_len = ^cfg_valid_len;
  assign elem_in_range        = 1'b1;
`endif

  // Job FSM, vector counter and write-back alignment of strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      vec_cnt_q <= '0;
      num_vec_q <= '0;
      set_ifm_q <= '0;
      wb_zero_q <= 1'b0;
    end else begin
      set_ifm_q <= '0;
      wb_zero_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            num_vec_q <= cfg_num_vec;
            vec_cnt_q <= '0;
            state_q   <= (cfg_num_vec == '0) ? FIN : FETCH;
          end
        end
        FETCH: begin
          set_ifm_q <= NUM_PE'(1) << elem;
          wb_zero_q <= !elem_in_range;
          if (elem_last) state_q <= DRAIN;
        end
        DRAIN: state_q <= HOLD;
        HOLD: begin
          if (vec_ready) begin
            if (last_vec) begin
              state_q <= FIN;
            end else begin
              vec_cnt_q <= vec_cnt_q + CNT_WIDTH'(1);
              state_q   <= FETCH;
            end
          end
        end
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_rd_en = (state_q == FETCH) && elem_in_range;
  assign set_ifm   = set_ifm_q;
  assign ifm_data  = (|set_ifm_q && !wb_zero_q) ? mem_rd_data : '0;
  assign vec_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);

endmodule

// File: tb/tb_ifm_load_ctrl.sv
// Scoreboard bench for ifm_load_ctrl (NUM_PE=4). A job-level reference model
// lists every expected SRAM read and buffer write-back; a monitor pops and
// compares them whenever the DUT strobes. Build with +define+IFM_LOAD_ZPAD_EN
// to exercise zero padding.
module tb_ifm_load_ctrl;

  localparam int DW   = 8;
  localparam int NPE  = 4;
  localparam int AW   = 16;
  localparam int CW   = 12;
  localparam int VL_W = $clog2(NPE + 1);

  logic            clk, rst_n, start;
  logic [AW-1:0]   cfg_base_addr, cfg_stride;
  logic [CW-1:0]   cfg_num_vec;
  logic [VL_W-1:0] cfg_valid_len;
  logic            mem_rd_en;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_rd_data;
  logic [NPE-1:0]  set_ifm;
  logic [DW-1:0]   ifm_data;
  logic            vec_valid, vec_ready, busy, done;

  ifm_load_ctrl #(.DATA_WIDTH(DW), .NUM_PE(NPE), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_base_addr(cfg_base_addr), .cfg_stride(cfg_stride),
    .cfg_num_vec(cfg_num_vec), .cfg_valid_len(cfg_valid_len),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .set_ifm(set_ifm), .ifm_data(ifm_data),
    .vec_valid(vec_valid), .vec_ready(vec_ready),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM contents are a fixed function of the address.
  function automatic logic [DW-1:0] sram_word(input logic [AW-1:0] a);
    return (a[7:0] ^ a[15:8]) ^ 8'h3C;
  endfunction

  // SRAM model: data valid the cycle after the read; junk otherwise.
  logic [AW-1:0] rd_addr_q;
  logic          rd_vld_q;
  always @(posedge clk) begin
    rd_vld_q  <= mem_rd_en;
    rd_addr_q <= mem_addr;
  end
  assign mem_rd_data = rd_vld_q ? sram_word(rd_addr_q) : 8'hEE;

  typedef struct {
    int            idx;
    logic [DW-1:0] data;
  } wr_t;

  logic [AW-1:0] exp_rd[$];
  wr_t           exp_wr[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int start_cyc, rd_first, valid_first, done_cyc, busy_cnt, done_cnt;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic fail_now(input string name, input logic [31:0] got);
    n_checks++;
    $display("FAIL %s: got %0h, expected no such event (cycle %0d)", name, got, cyc);
  endtask

  // Reference model: expected reads and write-backs of a whole job.
  task automatic model_job(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                           input logic [CW-1:0] nv, input logic [VL_W-1:0] vl);
    int  eff_vl;
    wr_t w;
`ifdef IFM_LOAD_ZPAD_EN
    eff_vl = (int'(vl) > NPE) ? NPE : int'(vl);
`else
    eff_vl = NPE;
`endif
    for (int v = 0; v < int'(nv); v++) begin
      for (int e = 0; e < NPE; e++) begin
        logic [AW-1:0] a;
        a = AW'(int'(base) + v * int'(stride) + e);
        w.idx = e;
        if (e < eff_vl) begin
          exp_rd.push_back(a);
          w.data = sram_word(a);
        end else begin
          w.data = '0;
        end
        exp_wr.push_back(w);
      end
    end
  endtask

  // Monitor: compare every strobe against the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (mem_rd_en) begin
        if (rd_first < 0) rd_first = cyc;
        if (exp_rd.size() == 0) fail_now("rd_unexpected", 32'(mem_addr));
        else check("rd_addr", 32'(mem_addr), 32'(exp_rd.pop_front()));
      end
      if (set_ifm != '0) begin
        if (exp_wr.size() == 0) fail_now("wr_unexpected", 32'(set_ifm));
        else begin
          wr_t w;
          logic [NPE-1:0] oh;
          w  = exp_wr.pop_front();
          oh = NPE'(1) << w.idx;
          check("wr_strobe", 32'(set_ifm), 32'(oh));
          check("wr_data", 32'(ifm_data), 32'(w.data));
        end
      end
      if (vec_valid) begin
        if (valid_first < 0) valid_first = cyc;
        check("hold_quiet", {31'd0, mem_rd_en} | 32'(set_ifm), 32'd0);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy) busy_cnt++;
    end
  end

  // Run one job. mode 0: vec_ready tied 1; 1: random vec_ready;
  // 2: stall 5 cycles in each HOLD with a start pulse and config noise.
  task automatic run_job(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                         input logic [CW-1:0] nv, input logic [VL_W-1:0] vl, input int mode);
    int budget, stall, run, vidx, done0;
    bit resume, got;
    model_job(base, stride, nv, vl);
    @(negedge clk);
    cfg_base_addr = base; cfg_stride = stride; cfg_num_vec = nv; cfg_valid_len = vl;
    start = 1'b1; vec_ready = (mode == 0);
    start_cyc = cyc; rd_first = -1; valid_first = -1; busy_cnt = 0; done0 = done_cnt;
    @(negedge clk);
    start = 1'b0;
    cfg_base_addr = AW'($urandom); cfg_stride = AW'($urandom);
    cfg_num_vec = CW'($urandom); cfg_valid_len = VL_W'($urandom);
    budget = 4000; stall = 0; run = 0; vidx = 0; resume = 0; got = 0;
    while (!got && budget > 0) begin
      if (done) got = 1;
      if (resume) begin
        resume = 0;
        check("resume_rd", {31'd0, mem_rd_en}, 32'd1);
      end
      case (mode)
        0: vec_ready = 1'b1;
        1: vec_ready = 1'($urandom_range(0, 1));
        default: begin
          if (vec_valid) begin
            run++;
            if (stall < 5) begin
              vec_ready = 1'b0; stall++; start = (stall == 2);
            end else begin
              vec_ready = 1'b1; stall = 0; start = 1'b0; vidx++;
              if (vidx < int'(nv)) resume = 1;
            end
          end else begin
            if (run > 0) begin
              check("hold_len", 32'(run), 32'd6);
              run = 0;
            end
            vec_ready = 1'b0; start = 1'b0;
          end
        end
      endcase
      if (!got) begin
        @(negedge clk);
        budget--;
      end
    end
    start = 1'b0; vec_ready = 1'b0;
    if (!got) begin
      fail_now("done_timeout", 32'(cyc));
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      exp_rd.delete();
      exp_wr.delete();
    end
    repeat (3) @(negedge clk);
    check("done_once", 32'(done_cnt - done0), 32'd1);
    check("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
    check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
    if (nv != '0) check("valid_latency", 32'(valid_first - start_cyc), 32'(NPE + 2));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"}, {31'd0, mem_rd_en}, 32'd0);
    check({tag, "_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_set_ifm"}, 32'(set_ifm), 32'd0);
    check({tag, "_ifm_data"}, 32'(ifm_data), 32'd0);
    check({tag, "_vec_valid"}, {31'd0, vec_valid}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    rst_n = 1'b0; start = 1'b0; vec_ready = 1'b0;
    cfg_base_addr = '0; cfg_stride = '0; cfg_num_vec = '0; cfg_valid_len = '0;
    rd_first = -1; valid_first = -1; done_cyc = 0; busy_cnt = 0; done_cnt = 0; start_cyc = 0;
    #3;
    check_all_zero("reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Basic two-vector job, vec_ready tied high.
    run_job(16'h0010, 16'd4, 12'd2, VL_W'(NPE), 0);
    check("first_rd_latency", 32'(rd_first - start_cyc), 32'd1);

    // Back-pressure in HOLD, start pulse and config noise ignored while busy.
    run_job(16'h0020, 16'd8, 12'd2, VL_W'(NPE), 2);

    // Address wrap within and across vectors.
    run_job(16'hFFFE, 16'd3, 12'd2, VL_W'(NPE), 0);

    // Empty job: immediate done, busy for exactly one cycle.
    run_job(16'h1234, 16'd5, 12'd0, VL_W'(NPE), 0);
    check("zero_done_latency", 32'(done_cyc - start_cyc), 32'd1);
    check("zero_busy_cycles", 32'(busy_cnt), 32'd1);

    // Abort mid-FETCH of vector 1, then restart from a new base.
    model_job(16'h0100, 16'h0010, 12'd2, VL_W'(NPE));
    @(negedge clk);
    cfg_base_addr = 16'h0100; cfg_stride = 16'h0010; cfg_num_vec = 12'd2;
    cfg_valid_len = VL_W'(NPE); start = 1'b1; vec_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_in_fetch", {31'd0, mem_rd_en}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("abort");
    exp_rd.delete();
    exp_wr.delete();
    d0 = done_cnt;
    @(negedge clk); rst_n = 1'b1; vec_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_idle", {31'd0, busy}, 32'd0);
    run_job(16'h0400, 16'h0020, 12'd3, VL_W'(NPE), 0);

`ifdef IFM_LOAD_ZPAD_EN
    // Partial vectors: padded slots strobe with zero data and no read.
    run_job(16'h0050, 16'd4, 12'd2, VL_W'(2), 0);
    run_job(16'h0060, 16'd4, 12'd1, VL_W'(0), 0);
    run_job(16'h0070, 16'd4, 12'd2, VL_W'(NPE + 1), 1);
`endif

    // Randomized jobs.
    for (int j = 0; j < 8; j++) begin
      run_job(AW'($urandom), AW'($urandom), CW'($urandom_range(1, 3)),
              VL_W'($urandom_range(0, NPE + 1)), 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
